// File: rtl/spu_pkg.sv
// Shared SPU definitions for the local-store pipe: opcode encodings,
// instruction format codes, pipe state and quadword width.
package spu_pkg;

  localparam int QW_W = 128;

  localparam logic [2:0] FMT_RR   = 3'd0;
  localparam logic [2:0] FMT_RI10 = 3'd4;
  localparam logic [2:0] FMT_RI16 = 3'd5;

  // Full 11-bit opcodes for the RR form; RI10/RI16 forms compare only the
  // low 8/9 opcode bits because the rest of the field carries immediate.
  localparam logic [10:0] OP_LQX  = 11'b00111000100;
  localparam logic [10:0] OP_STQX = 11'b00101000100;
  localparam logic [7:0]  OP_LQD  = 8'b00110100;
  localparam logic [7:0]  OP_STQD = 8'b00100100;
  localparam logic [8:0]  OP_LQA  = 9'b001100001;
  localparam logic [8:0]  OP_STQA = 9'b001000001;

  typedef enum logic {INIT, RUN} ls_state_t;

  // Power-on pattern for entry idx: words 4i..4i+3, word 0 most significant.
  function automatic logic [QW_W-1:0] init_entry(input logic [31:0] idx);
    logic [31:0] base;
    base = idx << 2;
    return {base, base + 32'd1, base + 32'd2, base + 32'd3};
  endfunction

endpackage

// File: rtl/ls_dma_arbiter.sv
// Grants the single memory port to DMA when the SPU is not using it, and
// forces a one-cycle SPU stall after DMA_STARVE consecutive denials.
module ls_dma_arbiter
  import spu_pkg::*;
#(
  parameter int DMA_STARVE = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic ls_mem_op,
  input  logic dma_req,
  output logic stall,
  output logic dma_gnt
);

  localparam int CW = $clog2(DMA_STARVE + 1);

  logic [CW-1:0] deny_cnt_q, deny_cnt_d;

  // Kept as separate assigns: ls_mem_op is itself gated by stall upstream.
  assign stall   = run && (deny_cnt_q == CW'(DMA_STARVE));
  assign dma_gnt = run && dma_req && (stall || !ls_mem_op);

  always_comb begin
    deny_cnt_d = deny_cnt_q;
    if (stall || dma_gnt) begin
      deny_cnt_d = '0;
    end else if (run && dma_req) begin
      deny_cnt_d = deny_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deny_cnt_q <= '0;
    end else begin
      deny_cnt_q <= deny_cnt_d;
    end
  end

endmodule

// File: rtl/local_store_pipe.sv
// SPU odd-pipe local store: quadword loads/stores, post-reset memory fill,
// result delay line with forwarding tags, and a shared DMA channel.
module local_store_pipe
  import spu_pkg::*;
#(
  parameter int MEM_DEPTH  = 2048,
  parameter int DEPTH      = 6,
  parameter int WB_STAGE   = 4,
  parameter int DMA_STARVE = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [10:0]           op,
  input  logic [2:0]            format,
  input  logic [6:0]            rt_addr,
  input  logic [QW_W-1:0]       ra,
  input  logic [QW_W-1:0]       rb,
  input  logic [QW_W-1:0]       rt_st,
  input  logic [17:0]           imm,
  input  logic                  reg_write,
  input  logic                  branch_taken,
  output logic                  ls_ready,
  output logic [QW_W-1:0]       rt_wb,
  output logic [6:0]            rt_addr_wb,
  output logic                  reg_write_wb,
  output logic [DEPTH*7-1:0]    rt_addr_delay,
  output logic [DEPTH-1:0]      reg_write_delay,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [31:0]           dma_addr,
  input  logic [QW_W-1:0]       dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [QW_W-1:0]       dma_rdata
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [QW_W-1:0] mem [MEM_DEPTH];

  ls_state_t       state_q, state_d;
  logic [AW-1:0]   init_cnt_q, init_cnt_d;
  logic [QW_W-1:0] val_q [DEPTH];
  logic [QW_W-1:0] val_d [DEPTH];
  logic [6:0]      tag_q [DEPTH];
  logic [6:0]      tag_d [DEPTH];
  logic [DEPTH-1:0] we_q, we_d;
  logic            dma_rvalid_q, dma_rvalid_d;
  logic [QW_W-1:0] dma_rdata_q, dma_rdata_d;

  logic            run, stall, is_load, is_store, mem_op;
  logic [31:0]     ea;
  logic [AW-1:0]   ls_idx, dma_idx, wr_idx;
  logic            wr_en;
  logic [QW_W-1:0] wr_data;
  logic            unused_ok;

  // SPU numbers bits MSB-first, so the preferred word [0:31] is [127:96].
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    ea       = '0;
    case (format)
      FMT_RR: begin
        ea       = ra[127:96] + rb[127:96];
        is_load  = (op == OP_LQX);
        is_store = (op == OP_STQX);
      end
      FMT_RI10: begin
        ea       = ra[127:96] + {{18{imm[9]}}, imm[9:0], 4'b0000};
        is_load  = (op[7:0] == OP_LQD);
        is_store = (op[7:0] == OP_STQD);
      end
      FMT_RI16: begin
        ea       = {{14{imm[15]}}, imm[15:0], 2'b00};
        is_load  = (op[8:0] == OP_LQA);
        is_store = (op[8:0] == OP_STQA);
      end
      default: ;
    endcase
  end

  assign run      = (state_q == RUN);
  assign ls_ready = run && !stall;
  assign mem_op   = ls_ready && !branch_taken && (is_load || is_store);
  assign ls_idx   = ea[4 +: AW];
  assign dma_idx  = dma_addr[4 +: AW];
  assign unused_ok = ^{ra[95:0], rb[95:0], imm[17:16], ea, dma_addr};

  ls_dma_arbiter #(.DMA_STARVE(DMA_STARVE)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .ls_mem_op (mem_op),
    .dma_req   (dma_req),
    .stall     (stall),
    .dma_gnt   (dma_gnt)
  );

  // Single write port; the arbiter guarantees store and DMA write never coincide.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = ls_idx;
    wr_data = rt_st;
    if (!run) begin
      wr_en   = 1'b1;
      wr_idx  = init_cnt_q;
      wr_data = init_entry(32'(init_cnt_q));
    end else if (mem_op && is_store) begin
      wr_en = 1'b1;
    end else if (dma_gnt && dma_we) begin
      wr_en   = 1'b1;
      wr_idx  = dma_idx;
      wr_data = dma_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (!run) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == AW'(MEM_DEPTH - 1)) begin
        state_d = RUN;
      end
    end
    val_d[0] = (mem_op && is_load) ? mem[ls_idx] : '0;
    tag_d[0] = mem_op ? rt_addr : '0;
    we_d[0]  = mem_op && is_load && reg_write;
    for (int k = 1; k < DEPTH; k++) begin
      val_d[k] = val_q[k-1];
      tag_d[k] = tag_q[k-1];
      we_d[k]  = we_q[k-1];
    end
    dma_rvalid_d = dma_gnt && !dma_we;
    dma_rdata_d  = dma_rvalid_d ? mem[dma_idx] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= INIT;
      init_cnt_q   <= '0;
      we_q         <= '0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        val_q[k] <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      we_q         <= we_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
      for (int k = 0; k < DEPTH; k++) begin
        val_q[k] <= val_d[k];
        tag_q[k] <= tag_d[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      rt_addr_delay[k*7 +: 7] = tag_q[k];
    end
  end

  assign reg_write_delay = we_q;
  assign rt_wb           = val_q[WB_STAGE];
  assign rt_addr_wb      = tag_q[WB_STAGE];
  assign reg_write_wb    = we_q[WB_STAGE];
  assign dma_rvalid      = dma_rvalid_q;
  assign dma_rdata       = dma_rdata_q;

endmodule

// File: tb/tb_local_store_pipe.sv
// Directed bench for local_store_pipe: init fill, load/store forms, wrap,
// branch cancel, DMA access and starvation stall, reset restart.
module tb_local_store_pipe;

  localparam int DEPTH = 6;
  localparam logic [127:0] ENT1 = 128'h00000004_00000005_00000006_00000007;
  localparam logic [127:0] ENT4 = 128'h00000010_00000011_00000012_00000013;
  localparam logic [10:0] LQX  = 11'b00111000100;
  localparam logic [10:0] LQD  = 11'b00000110100;
  localparam logic [10:0] STQD = 11'b00000100100;
  localparam logic [10:0] LQA  = 11'b00001100001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [10:0] op;
  logic [2:0] format;
  logic [6:0] rt_addr;
  logic [127:0] ra, rb, rt_st;
  logic [17:0] imm;
  logic reg_write, branch_taken;
  logic ls_ready;
  logic [127:0] rt_wb;
  logic [6:0] rt_addr_wb;
  logic reg_write_wb;
  logic [DEPTH*7-1:0] rt_addr_delay;
  logic [DEPTH-1:0] reg_write_delay;
  logic dma_req, dma_we;
  logic [31:0] dma_addr;
  logic [127:0] dma_wdata;
  logic dma_gnt, dma_rvalid;
  logic [127:0] dma_rdata;

  int passed = 0;
  int total = 0;

  local_store_pipe dut (
    .clk             (clk),
    .reset           (reset),
    .op              (op),
    .format          (format),
    .rt_addr         (rt_addr),
    .ra              (ra),
    .rb              (rb),
    .rt_st           (rt_st),
    .imm             (imm),
    .reg_write       (reg_write),
    .branch_taken    (branch_taken),
    .ls_ready        (ls_ready),
    .rt_wb           (rt_wb),
    .rt_addr_wb      (rt_addr_wb),
    .reg_write_wb    (reg_write_wb),
    .rt_addr_delay   (rt_addr_delay),
    .reg_write_delay (reg_write_delay),
    .dma_req         (dma_req),
    .dma_we          (dma_we),
    .dma_addr        (dma_addr),
    .dma_wdata       (dma_wdata),
    .dma_gnt         (dma_gnt),
    .dma_rvalid      (dma_rvalid),
    .dma_rdata       (dma_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic nop();
    format = 3'd0; op = 11'd0; imm = 18'd0; ra = '0; rb = '0;
    rt_addr = 7'd0; reg_write = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic drive(input logic [2:0] f, input logic [10:0] o, input logic [17:0] im,
                       input logic [31:0] a, input logic [31:0] b, input logic [6:0] rt,
                       input logic br);
    format = f; op = o; imm = im; ra = {a, 96'h0}; rb = {b, 96'h0};
    rt_addr = rt; reg_write = 1'b1; branch_taken = br;
  endtask

  initial begin
    int hi_cnt;
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    nop();
    rt_st = '0; dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    tick(3);

    chk("rst_ls_ready", 128'(ls_ready), 128'd0);
    chk("rst_we_delay", 128'(reg_write_delay), 128'd0);
    chk("rst_tags", 128'(rt_addr_delay), 128'd0);
    chk("rst_dma_flags", 128'({dma_gnt, dma_rvalid}), 128'd0);
    chk("rst_dma_rdata", dma_rdata, 128'd0);

    // Full memory fill: 2048 cycles without acceptance.
    reset = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 2048; i++) begin
      #2;
      if (ls_ready) hi_cnt++;
      tick();
    end
    chk("init_ready_low_cycles", 128'(hi_cnt), 128'd0);
    chk("run_ready", 128'(ls_ready), 128'd1);

    // lqa byte 16 -> entry 1
    drive(3'd5, LQA, 18'h4, 32'h0, 32'h0, 7'd10, 1'b0);
    tick(); nop();
    #2;
    chk("lqa_tag0", 128'(rt_addr_delay[6:0]), 128'd10);
    chk("lqa_we0", 128'(reg_write_delay[0]), 128'd1);
    tick(4);
    chk("lqa_rt_wb", rt_wb, ENT1);
    chk("lqa_wb_en", 128'(reg_write_wb), 128'd1);
    chk("lqa_wb_addr", 128'(rt_addr_wb), 128'd10);

    // stqd then lqd to the same address on the next cycle
    rt_st = a5;
    drive(3'd4, STQD, 18'd1, 32'h20, 32'h0, 7'd20, 1'b0);
    tick();
    drive(3'd4, LQD, 18'd1, 32'h20, 32'h0, 7'd21, 1'b0);
    #2;
    chk("stqd_we0", 128'(reg_write_delay[0]), 128'd0);
    tick(); nop(); rt_st = '0;
    tick(4);
    chk("lqd_after_st_data", rt_wb, a5);
    chk("lqd_after_st_addr", 128'(rt_addr_wb), 128'd21);

    // lqx address wraps to entry 1
    drive(3'd0, LQX, 18'd0, 32'h7FFF0, 32'h20, 7'd5, 1'b0);
    tick(); nop();
    tick(4);
    chk("lqx_wrap_data", rt_wb, ENT1);
    chk("lqx_wrap_en", 128'(reg_write_wb), 128'd1);

    // branch cancels the load
    drive(3'd0, LQX, 18'd0, 32'h10, 32'h0, 7'd6, 1'b1);
    tick(); nop();
    #2;
    chk("br_tag0", 128'(rt_addr_delay[6:0]), 128'd0);
    chk("br_we0", 128'(reg_write_delay[0]), 128'd0);
    tick(4);
    chk("br_rt_wb", rt_wb, 128'd0);
    chk("br_wb_en", 128'(reg_write_wb), 128'd0);

    // DMA write then read back
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 128'h1234;
    #2;
    chk("dma_wr_gnt", 128'(dma_gnt), 128'd1);
    tick();
    dma_we = 1'b0; dma_wdata = '0;
    #2;
    chk("dma_rd_gnt", 128'(dma_gnt), 128'd1);
    tick();
    dma_req = 1'b0; dma_addr = '0;
    #2;
    chk("dma_rvalid", 128'(dma_rvalid), 128'd1);
    chk("dma_rdata", dma_rdata, 128'h1234);
    tick();
    chk("dma_rvalid_drop", 128'(dma_rvalid), 128'd0);

    // starvation: continuous loads with DMA read of entry 1 pending
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
    drive(3'd5, LQA, 18'h4, 32'h0, 32'h0, 7'd9, 1'b0);
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      #2;
      if (!ls_ready || dma_gnt) hi_cnt++;
      tick();
    end
    chk("starve_denied_cycles", 128'(hi_cnt), 128'd0);
    #2;
    chk("starve_ready_low", 128'(ls_ready), 128'd0);
    chk("starve_gnt", 128'(dma_gnt), 128'd1);
    tick();
    dma_req = 1'b0;
    #2;
    chk("starve_ready_back", 128'(ls_ready), 128'd1);
    chk("starve_rvalid", 128'(dma_rvalid), 128'd1);
    chk("starve_rdata", dma_rdata, ENT1);
    chk("stall_bubble_we0", 128'(reg_write_delay[0]), 128'd0);
    chk("stall_prev_we1", 128'(reg_write_delay[1]), 128'd1);
    tick();

    // reset in RUN clears the pipe
    reset = 1'b0;
    #1;
    chk("run_reset_we_clear", 128'(reg_write_delay), 128'd0);
    chk("run_reset_ready", 128'(ls_ready), 128'd0);
    nop();
    tick(2);
    reset = 1'b1;
    tick(1000);
    // reset part-way through the fill restarts it
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 2048; i++) begin
      #2;
      if (ls_ready) hi_cnt++;
      tick();
    end
    chk("reinit_ready_low_cycles", 128'(hi_cnt), 128'd0);
    chk("reinit_run_ready", 128'(ls_ready), 128'd1);

    // entry 4 was overwritten by DMA; the refill restores it
    drive(3'd5, LQA, 18'h10, 32'h0, 32'h0, 7'd3, 1'b0);
    tick(); nop();
    tick(4);
    chk("reinit_entry4", rt_wb, ENT4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/local_store_pipe.md
# local_store_pipe

Parametrised successor to the SPU local-store pipe in the odd (load/store) execution pipeline. It executes lqx/stqx/lqd/stqd/lqa/stqa against a configurable-depth quadword memory through a configurable-length result delay line. Over the earlier block it adds byte addressing with wrap-around, branch-flush, a post-reset memory-initialisation state machine, and a second memory channel for DMA with starvation-bounded arbitration. It sits between RF/FWD and the register-table writeback; its delay-line tags feed the forwarding/hazard unit.

## Interface
- MEM_DEPTH, 2048: quadword entries (power of two; 2048 = 32 KB)
- DEPTH, 6: result delay-line stages
- WB_STAGE, 4: delay stage driven onto the writeback outputs (< DEPTH)
- DMA_STARVE, 8: consecutive denied DMA cycles before an SPU stall is forced
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- op  in  11  decoded opcode, truncated per format
- format  in  3  instruction format
- rt_addr  in  7  destination register
- ra, rb, rt_st  in  128 each  source operand values; only [0:31] of ra/rb used
- imm  in  18  immediate
- reg_write  in  1  instruction writes register table
- branch_taken  in  1  cancel the instruction presented this cycle
- ls_ready  out  1  high = instruction accepted this cycle
- rt_wb  out  128  writeback value
- rt_addr_wb  out  7  writeback destination
- reg_write_wb  out  1  writeback enable
- rt_addr_delay  out  DEPTH×7  per-stage destination tags
- reg_write_delay  out  DEPTH  per-stage write enables
- dma_req, dma_we  in  1 each  DMA request / write
- dma_addr  in  32  DMA byte address
- dma_wdata  in  128  DMA write data
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  read data valid (one cycle after grant)
- dma_rdata  out  128  DMA read data

## Operation
- State machine INIT → RUN. Reset asserted: state = INIT, init counter = 0, all delay stages, ls_ready, dma_gnt, dma_rvalid, dma_rdata cleared to 0.
- INIT: one entry per cycle, entry i ← {4i, 4i+1, 4i+2, 4i+3} (four 32-bit words). ls_ready = 0, dma_gnt = 0. After entry MEM_DEPTH−1 is written → RUN. Memory has no reset of its own.
- RUN: ls_ready = 1, except in a cycle the starvation stall is taken.
- Every accepted cycle the delay line shifts stage k → k+1; stage 0 loads the new instruction. Stage 0 is loaded with zero value, tag and enable for nop (format 0, op 0), branch_taken, an unrecognised opcode, or an unaccepted cycle.
- Byte address, then index = addr[bits 4 up to 4+log2(MEM_DEPTH)−1] (low 4 bits ignored, upper bits wrap):
  - lqx 00111000100 / stqx 00101000100 (format 0): ra[0:31] + rb[0:31]
  - lqd op[3:10]=00110100 / stqd 00100100 (format 4): ra[0:31] + (sext(imm[8:17]) << 4)
  - lqa op[2:10]=001100001 / stqa 001000001 (format 5): sext(imm[2:17]) << 2
- Loads: stage-0 value = mem[index], with reg_write passed through. Stores: mem[index] ← rt_st, stage-0 reg_write forced to 0.
- Arbitration: DMA is granted when in RUN and the current cycle carries no accepted load/store. The denied counter increments on each denied dma_req and clears on grant. When it reaches DMA_STARVE, the next cycle drops ls_ready, grants DMA, and clears the counter.
- DMA write: mem ← dma_wdata at the grant edge. DMA read: dma_rdata/dma_rvalid valid in the following cycle.

## Timing
- Instruction in cycle N → rt_wb in cycle N+WB_STAGE+1 (default N+5). Tags are visible at stage k in cycle N+k+1.
- A store in cycle N is visible to a load in cycle N+1. A DMA write is visible to any access in the next cycle.
- Only one memory access is granted per cycle, so same-address write collisions cannot occur.
- Reset mid-INIT restarts the counter at 0. Reset in RUN clears the pipe and re-enters INIT.
- ls_ready = 0 means upstream must hold the instruction; the held instruction is not executed in that cycle.

## Structure
- Shared package spu_pkg: opcode constants (format 0/4/5 encodings), format codes, ls_state_t {INIT, RUN}, QW_W = 128.
- Sub-module ls_dma_arbiter: grant logic, starvation counter and stall generation. Memory array, INIT FSM and delay line stay in the top module.

## Test plan
- Reset release → ls_ready = 0 for 2048 cycles; then lqa imm = 0x0004 (byte 16, entry 1) → rt_wb = {4,5,6,7} at N+5 with reg_write_wb = 1.
- stqd ra = 0x20, imm = 1, rt_st = 0xA5…A5 at N; lqd same address at N+1 → rt_wb = 0xA5…A5 at N+6; the store's reg_write_delay[0] = 0.
- lqx ra = 0x7FFF0, rb = 0x20 → index wraps to 1 → {4,5,6,7}.
- lqx with branch_taken = 1 → all stage-0 fields 0; rt_wb = 0 and reg_write_wb = 0 five cycles later.
- dma_req write of 0x1234 to 0x40 with no SPU memory op → dma_gnt the same cycle; DMA read of 0x40 the next cycle → dma_rvalid with 0x1234 one cycle later.
- Continuous loads plus dma_req held → 8 denied cycles, then ls_ready = 0 for one cycle with dma_gnt = 1; reset asserted mid-INIT restarts the full 2048-cycle init.
